// File: rtl/sramlike_arbiter_if.sv
// One sram-like port: request/address phase from the master, addr_ok/data_ok/rdata back.
interface sramlike_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sramlike_arbiter.sv
// Shares one sram-like memory port between the inst and data masters, with in-order
// response routing through an owner FIFO and a fetch starvation guard.
//
// state        | meaning
// ST_OPEN      | no address phase pending, arbitrate freely
// ST_LOCK_INST | inst request offered but not taken, grant frozen on inst
// ST_LOCK_DATA | data request offered but not taken, grant frozen on data
module sramlike_arbiter #(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  sramlike_arbiter_if.slave    inst_bus,
  sramlike_arbiter_if.slave    data_bus,
  sramlike_arbiter_if.master   mem_bus
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [SW-1:0] stv_t;

  localparam ptr_t PTR_LAST = ptr_t'(MAX_OUTST - 1);
  localparam cnt_t CNT_FULL = cnt_t'(MAX_OUTST);
  localparam stv_t STV_MAX  = stv_t'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_OPEN      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic owner_q [MAX_OUTST];
  ptr_t wr_ptr, rd_ptr;
  cnt_t count;
  stv_t starve_cnt;

  logic fifo_full;
  logic gnt_inst, gnt_data;
  logic mem_req_int;
  logic accept;
  logic pop;
  logic head_owner;

  assign fifo_full  = (count == CNT_FULL);
  assign head_owner = owner_q[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_OPEN;
    else       state <= state_nxt;
  end

  always_comb begin
    gnt_inst    = 1'b0;
    gnt_data    = 1'b0;
    mem_req_int = 1'b0;
    accept      = 1'b0;
    state_nxt   = state;
    case (state)
      ST_LOCK_INST: gnt_inst = 1'b1;
      ST_LOCK_DATA: gnt_data = 1'b1;
      default: begin
        // data normally wins; inst gets one forced slot once data has starved it
        if (data_bus.req && !(inst_bus.req && (starve_cnt == STV_MAX))) gnt_data = 1'b1;
        else if (inst_bus.req)                                           gnt_inst = 1'b1;
      end
    endcase
    mem_req_int = ((gnt_inst & inst_bus.req) | (gnt_data & data_bus.req))
                  & ~fifo_full & ~reset;
    accept      = mem_req_int & mem_bus.addr_ok;
    if (accept)           state_nxt = ST_OPEN;
    else if (mem_req_int) state_nxt = gnt_inst ? ST_LOCK_INST : ST_LOCK_DATA;
  end

  assign mem_bus.req   = mem_req_int;
  assign mem_bus.wr    = gnt_inst ? inst_bus.wr    : data_bus.wr;
  assign mem_bus.size  = gnt_inst ? inst_bus.size  : data_bus.size;
  assign mem_bus.wstrb = gnt_inst ? inst_bus.wstrb : data_bus.wstrb;
  assign mem_bus.addr  = gnt_inst ? inst_bus.addr  : data_bus.addr;
  assign mem_bus.wdata = gnt_inst ? inst_bus.wdata : data_bus.wdata;

  assign inst_bus.addr_ok = accept & gnt_inst;
  assign data_bus.addr_ok = accept & gnt_data;

  // responses with nothing outstanding are dropped
  assign pop = mem_bus.data_ok & (count != '0);

  assign inst_bus.data_ok = pop & ~head_owner;
  assign data_bus.data_ok = pop &  head_owner;
  assign inst_bus.rdata   = mem_bus.rdata;
  assign data_bus.rdata   = mem_bus.rdata;

  always_ff @(posedge clk) begin
    if (accept) owner_q[wr_ptr] <= gnt_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ptr_t'(1);
      if (pop)    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + ptr_t'(1);
      case ({accept, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (accept && gnt_data && inst_bus.req) begin
      if (starve_cnt != STV_MAX) starve_cnt <= starve_cnt + stv_t'(1);
    end else if ((accept && gnt_inst) || !inst_bus.req) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_sramlike_arbiter;
  localparam int MAX_OUTST    = 4;
  localparam int STARVE_LIMIT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sramlike_arbiter_if inst_bus();
  sramlike_arbiter_if data_bus();
  sramlike_arbiter_if mem_bus();

  sramlike_arbiter #(.MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .inst_bus (inst_bus),
    .data_bus (data_bus),
    .mem_bus  (mem_bus)
  );

  int tests = 0;
  int fails = 0;

  // model state: owners of accepted, unanswered requests, pending held grant, data streak
  bit    owners[$];
  int    held   = -1;
  int    streak = 0;
  bit    acc_i, acc_d;
  string acc_log;

  logic        obs_mem_req, obs_iaok, obs_daok, obs_idok, obs_ddok;
  logic [31:0] obs_irdata, obs_drdata, obs_mem_addr;

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [70:0] fields_i();
    return {inst_bus.wr, inst_bus.size, inst_bus.wstrb, inst_bus.addr, inst_bus.wdata};
  endfunction

  function automatic logic [70:0] fields_d();
    return {data_bus.wr, data_bus.size, data_bus.wstrb, data_bus.addr, data_bus.wdata};
  endfunction

  function automatic logic [70:0] fields_m();
    return {mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata};
  endfunction

  task automatic cycle();
    int g;
    bit want, e_req, acc, resp, head;
    @(negedge clk);
    if (held >= 0)                                                     g = held;
    else if (data_bus.req && !(inst_bus.req && streak == STARVE_LIMIT)) g = 1;
    else if (inst_bus.req)                                             g = 0;
    else                                                               g = -1;
    want  = (g == 0 && inst_bus.req) || (g == 1 && data_bus.req);
    e_req = want && (owners.size() < MAX_OUTST) && !reset;
    acc   = e_req && mem_bus.addr_ok;
    resp  = mem_bus.data_ok && (owners.size() > 0) && !reset;
    head  = resp ? owners[0] : 1'b0;

    obs_mem_req  = mem_bus.req;
    obs_iaok     = inst_bus.addr_ok;
    obs_daok     = data_bus.addr_ok;
    obs_idok     = inst_bus.data_ok;
    obs_ddok     = data_bus.data_ok;
    obs_irdata   = inst_bus.rdata;
    obs_drdata   = data_bus.rdata;
    obs_mem_addr = mem_bus.addr;

    chk("mem_req",      mem_bus.req,      e_req);
    chk("inst_addr_ok", inst_bus.addr_ok, acc && g == 0);
    chk("data_addr_ok", data_bus.addr_ok, acc && g == 1);
    chk("inst_data_ok", inst_bus.data_ok, resp && !head);
    chk("data_data_ok", data_bus.data_ok, resp && head);
    if (e_req) chk("mem_fields", fields_m(), (g == 0) ? fields_i() : fields_d());
    if (resp)  chk("rdata", head ? data_bus.rdata : inst_bus.rdata, mem_bus.rdata);

    if (mem_bus.req && mem_bus.addr_ok) acc_log = {acc_log, inst_bus.addr_ok ? "I" : "D"};

    acc_i = acc && g == 0;
    acc_d = acc && g == 1;
    if (reset) begin
      owners.delete();
      held   = -1;
      streak = 0;
    end else begin
      if (resp) void'(owners.pop_front());
      if (acc)  owners.push_back(g == 1);
      if (acc)        held = -1;
      else if (e_req) held = g;
      if (acc_d && inst_bus.req)        streak = (streak < STARVE_LIMIT) ? streak + 1 : streak;
      else if (acc_i || !inst_bus.req)  streak = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(bit req, logic [31:0] a);
    inst_bus.req = req; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
    inst_bus.wstrb = 4'h0; inst_bus.addr = a; inst_bus.wdata = 32'h0;
  endtask

  task automatic set_data(bit req, bit wr, logic [31:0] a, logic [31:0] wd);
    data_bus.req = req; data_bus.wr = wr; data_bus.size = 2'd2;
    data_bus.wstrb = wr ? 4'hf : 4'h0; data_bus.addr = a; data_bus.wdata = wd;
  endtask

  task automatic set_mem(bit aok, bit dok, logic [31:0] rd);
    mem_bus.addr_ok = aok; mem_bus.data_ok = dok; mem_bus.rdata = rd;
  endtask

  task automatic drain();
    int n = 0;
    set_mem(1'b1, 1'b1, 32'hd0d0_0000);
    while ((inst_bus.req || data_bus.req || owners.size() > 0) && n < 40) begin
      cycle();
      if (acc_i) inst_bus.req = 1'b0;
      if (acc_d) data_bus.req = 1'b0;
      mem_bus.rdata = $urandom;
      n++;
    end
    chk("drain_done", (n < 40), 1'b1);
    set_mem(1'b0, 1'b0, 32'h0);
  endtask

  task automatic rand_masters();
    if (!inst_bus.req || acc_i) begin
      set_inst($urandom_range(99) < 50, $urandom);
      inst_bus.wr = $urandom_range(1); inst_bus.size = 2'($urandom_range(3));
      inst_bus.wstrb = 4'($urandom); inst_bus.wdata = $urandom;
    end
    if (!data_bus.req || acc_d) begin
      set_data($urandom_range(99) < 60, 1'($urandom_range(1)), $urandom, $urandom);
      data_bus.size = 2'($urandom_range(3));
    end
    set_mem($urandom_range(99) < 60, $urandom_range(99) < 45, $urandom);
  endtask

  initial begin
    reset = 1'b1;
    set_inst(1'b1, 32'hbfc0_0000);
    set_data(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    set_mem(1'b1, 1'b1, 32'h1111_1111);
    cycle();
    chk("reset_mem_req", obs_mem_req, 1'b0);
    chk("reset_data_ok", {obs_idok, obs_ddok}, 2'b00);
    cycle();
    reset = 1'b0;
    set_inst(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0, 32'h0);
    set_mem(1'b0, 1'b0, 32'h0);
    cycle();

    // single inst read, response two cycles after accept
    set_inst(1'b1, 32'hbfc0_0000);
    set_mem(1'b1, 1'b0, 32'h0);
    cycle();
    chk("t1_inst_addr_ok", obs_iaok, 1'b1);
    set_inst(1'b0, 32'h0);
    set_mem(1'b0, 1'b0, 32'h0);
    cycle();
    set_mem(1'b0, 1'b1, 32'h2402_0001);
    cycle();
    chk("t1_inst_data_ok", obs_idok, 1'b1);
    chk("t1_inst_rdata", obs_irdata, 32'h2402_0001);
    chk("t1_data_data_ok", obs_ddok, 1'b0);
    set_mem(1'b0, 1'b0, 32'h0);

    // simultaneous requests: data first, then inst, responses in order
    set_inst(1'b1, 32'hbfc0_0004);
    set_data(1'b1, 1'b0, 32'h8000_0010, 32'h0);
    set_mem(1'b1, 1'b0, 32'h0);
    cycle();
    chk("t2_first_data", {obs_daok, obs_iaok}, 2'b10);
    set_data(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("t2_then_inst", {obs_daok, obs_iaok}, 2'b01);
    set_inst(1'b0, 32'h0);
    set_mem(1'b0, 1'b1, 32'haaaa_0001);
    cycle();
    chk("t2_resp_a", {obs_ddok, obs_idok, obs_drdata}, {2'b10, 32'haaaa_0001});
    mem_bus.rdata = 32'hbbbb_0002;
    cycle();
    chk("t2_resp_b", {obs_ddok, obs_idok, obs_irdata}, {2'b01, 32'hbbbb_0002});
    set_mem(1'b0, 1'b0, 32'h0);
    cycle();

    // starvation guard: D,D,D,I repeating
    acc_log = "";
    set_inst(1'b1, 32'hbfc0_0100);
    set_data(1'b1, 1'b1, 32'h8000_0100, 32'h5555_aaaa);
    set_mem(1'b1, 1'b1, 32'h3333_3333);
    for (int i = 0; i < 8; i++) begin
      cycle();
      data_bus.addr = data_bus.addr + 32'd4;
    end
    tests++;
    assert (acc_log == "DDDIDDDI") else begin
      fails++;
      $error("FAIL t3_grant_order observed=%s expected=DDDIDDDI", acc_log);
    end
    drain();

    // address phase stall locks grant on inst
    set_inst(1'b1, 32'hbfc0_0200);
    set_mem(1'b0, 1'b0, 32'h0);
    cycle();
    set_data(1'b1, 1'b0, 32'h8000_0200, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t4_lock_addr", obs_mem_addr, 32'hbfc0_0200);
      chk("t4_no_data_aok", obs_daok, 1'b0);
    end
    mem_bus.addr_ok = 1'b1;
    cycle();
    chk("t4_inst_accept", {obs_iaok, obs_daok}, 2'b10);
    inst_bus.req = 1'b0;
    cycle();
    chk("t4_data_accept", obs_daok, 1'b1);
    data_bus.req = 1'b0;
    drain();

    // owner FIFO full blocking and push+pop
    set_data(1'b1, 1'b0, 32'h8000_0300, 32'h0);
    set_mem(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle();
    cycle();
    chk("t5_full_no_req", obs_mem_req, 1'b0);
    set_mem(1'b1, 1'b1, 32'h4444_0000);
    cycle();
    chk("t5_pop_still_blocked", {obs_mem_req, obs_ddok}, 2'b01);
    cycle();
    chk("t5_push_pop", {obs_daok, obs_ddok}, 2'b11);
    set_mem(1'b1, 1'b0, 32'h0);
    cycle();
    chk("t5_refill", obs_daok, 1'b1);
    cycle();
    chk("t5_full_again", obs_mem_req, 1'b0);
    data_bus.req = 1'b0;
    drain();

    // reset with two outstanding, then stray response is ignored
    set_inst(1'b1, 32'hbfc0_0400);
    set_mem(1'b1, 1'b0, 32'h0);
    cycle();
    inst_bus.req = 1'b0;
    set_data(1'b1, 1'b0, 32'h8000_0400, 32'h0);
    cycle();
    data_bus.req = 1'b0;
    set_mem(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_mem(1'b0, 1'b1, 32'h6666_6666);
    cycle();
    chk("t6_stray_ignored", {obs_idok, obs_ddok}, 2'b00);
    set_inst(1'b1, 32'hbfc0_0500);
    set_mem(1'b1, 1'b0, 32'h0);
    cycle();
    chk("t6_new_accept", obs_iaok, 1'b1);
    inst_bus.req = 1'b0;
    set_mem(1'b0, 1'b1, 32'h7777_0007);
    cycle();
    chk("t6_new_resp", {obs_idok, obs_irdata}, {1'b1, 32'h7777_0007});
    set_mem(1'b0, 1'b0, 32'h0);

    // randomized traffic
    acc_i = 1'b1;
    acc_d = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rand_masters();
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
